mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/gpu_mem_pkg.sv | 24 ++
 rtl/rr_picker.sv | 36 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared definitions for the memory arbiter slice.
//   - default width/count constants for mem_arbiter parameters
//   - ch_state_t: per-channel FSM state encoding
//   - idx_bits(): index width for a pool of n requesters (never below 1)
package gpu_mem_pkg;

    localparam int unsigned DEF_ADDR_BITS     = 8;
    localparam int unsigned DEF_DATA_BITS     = 8;
    localparam int unsigned DEF_NUM_CONSUMERS = 4;
    localparam int unsigned DEF_NUM_CHANNELS  = 1;

    typedef enum logic [2:0] {
        CH_IDLE,
        CH_READ_WAITING,
        CH_WRITE_WAITING,
        CH_READ_RELAYING,
        CH_WRITE_RELAYING
    } ch_state_t;

    function automatic int unsigned idx_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   i_req   - request mask, one bit per requester
//   i_start - index to start scanning from (scan wraps NUM_REQ-1 -> 0)
//   o_idx   - first requesting index at or after i_start
//   o_valid - at least one request present
module rr_picker #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [IDX_BITS-1:0] i_start,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_valid
);

    always_comb begin
        int unsigned w_pos;
        logic        w_found;
        o_idx   = '0;
        o_valid = 1'b0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = 32'(i_start) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!w_found && i_req[w_pos]) begin
                w_found = 1'b1;
                o_idx   = w_pos[IDX_BITS-1:0];
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares NUM_CHANNELS external memory channels among
// NUM_CONSUMERS per-thread load/store request ports.
// Each channel runs IDLE -> *_WAITING -> *_RELAYING -> IDLE. In IDLE it
// claims a requesting, unclaimed consumer round-robin; reads win over writes
// for a consumer asserting both. All outputs are registered.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   consumer_read_*             - per-consumer read request/address/ready/data
//   consumer_write_*            - per-consumer write request/address/data/ready
//   mem_read_*                  - per-channel memory read request/response
//   mem_write_*                 - per-channel memory write request/response
module mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
    parameter int unsigned NUM_CONSUMERS = DEF_NUM_CONSUMERS,
    parameter int unsigned NUM_CHANNELS  = DEF_NUM_CHANNELS
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],

    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address       [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data          [NUM_CHANNELS],

    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address      [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data         [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

    localparam int unsigned IW = idx_bits(NUM_CONSUMERS);

    ch_state_t               r_state [NUM_CHANNELS];
    logic [IW-1:0]           r_sel   [NUM_CHANNELS];  // consumer owned by channel
    logic [IW-1:0]           r_ptr   [NUM_CHANNELS];  // next round-robin start

    logic [NUM_CONSUMERS-1:0] w_claimed;
    logic [NUM_CONSUMERS-1:0] w_open;
    logic [IW-1:0]            w_gnt_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  w_gnt_ok;

    // A consumer stays claimed from the claim edge until its channel is
    // back in IDLE, so it is derived straight from channel state.
    always_comb begin
        w_claimed = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                if (r_state[c] != CH_IDLE && r_sel[c] == IW'(k)) begin
                    w_claimed[k] = 1'b1;
                end
            end
        end
    end

    assign w_open = (consumer_read_valid | consumer_write_valid) & ~w_claimed;

    // Channels pick in index order: each channel sees the open pool minus
    // whatever lower-indexed idle channels grabbed this same cycle.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] w_req;
        logic [IW-1:0]            w_idx;
        logic                     w_hit;
        logic                     w_ok;

        if (c == 0) begin : g_first
            assign w_req = w_open;
        end else begin : g_rest
            assign w_req = g_ch[c-1].w_req &
                           ~(g_ch[c-1].w_ok ? (NUM_CONSUMERS'(1) << g_ch[c-1].w_idx)
                                            : '0);
        end

        rr_picker #(
            .NUM_REQ  (NUM_CONSUMERS),
            .IDX_BITS (IW)
        ) u_pick (
            .i_req   (w_req),
            .i_start (r_ptr[c]),
            .o_idx   (w_idx),
            .o_valid (w_hit)
        );

        assign w_ok         = w_hit && (r_state[c] == CH_IDLE);
        assign w_gnt_idx[c] = w_idx;
        assign w_gnt_ok[c]  = w_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_write_valid      <= '0;
            for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                consumer_read_data[k] <= '0;
            end
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c]           <= CH_IDLE;
                r_sel[c]             <= '0;
                r_ptr[c]             <= '0;
                mem_read_address[c]  <= '0;
                mem_write_address[c] <= '0;
                mem_write_data[c]    <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                case (r_state[c])
                    CH_IDLE: begin
                        if (w_gnt_ok[c]) begin
                            r_sel[c] <= w_gnt_idx[c];
                            r_ptr[c] <= (w_gnt_idx[c] == IW'(NUM_CONSUMERS - 1))
                                        ? '0 : w_gnt_idx[c] + IW'(1);
                            if (consumer_read_valid[w_gnt_idx[c]]) begin
                                mem_read_valid[c]   <= 1'b1;
                                mem_read_address[c] <= consumer_read_address[w_gnt_idx[c]];
                                r_state[c]          <= CH_READ_WAITING;
                            end else begin
                                mem_write_valid[c]   <= 1'b1;
                                mem_write_address[c] <= consumer_write_address[w_gnt_idx[c]];
                                mem_write_data[c]    <= consumer_write_data[w_gnt_idx[c]];
                                r_state[c]           <= CH_WRITE_WAITING;
                            end
                        end
                    end
                    // The memory access always completes, even if the
                    // consumer has already dropped its request.
                    CH_READ_WAITING: begin
                        if (mem_read_ready[c]) begin
                            mem_read_valid[c]                <= 1'b0;
                            consumer_read_ready[r_sel[c]]    <= 1'b1;
                            consumer_read_data[r_sel[c]]     <= mem_read_data[c];
                            r_state[c]                       <= CH_READ_RELAYING;
                        end
                    end
                    CH_WRITE_WAITING: begin
                        if (mem_write_ready[c]) begin
                            mem_write_valid[c]               <= 1'b0;
                            consumer_write_ready[r_sel[c]]   <= 1'b1;
                            r_state[c]                       <= CH_WRITE_RELAYING;
                        end
                    end
                    CH_READ_RELAYING: begin
                        if (!consumer_read_valid[r_sel[c]]) begin
                            consumer_read_ready[r_sel[c]]    <= 1'b0;
                            r_state[c]                       <= CH_IDLE;
                        end
                    end
                    CH_WRITE_RELAYING: begin
                        if (!consumer_write_valid[r_sel[c]]) begin
                            consumer_write_ready[r_sel[c]]   <= 1'b0;
                            r_state[c]                       <= CH_IDLE;
                        end
                    end
                    default: begin
                        r_state[c] <= CH_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
